dfe_sample_capture: RTL

// - Hardware sink at the output of the Phase-1 DFE chain (ph1_chain_out/valid_out); captures strobed samples into a buffer.
// - Discards a programmable number of settling samples, then stores up to a programmed count.
// - A host drains the buffer over a valid/ready port; the sticky status records drops and the chain's overflow/underflow flags.

---
 rtl/dfe_pkg.sv | 19 +
 rtl/dfe_capture_fifo.sv | 73 +++++++
 rtl/dfe_sample_capture.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/dfe_pkg.sv
// Shared definitions for the DFE sample-capture block.
//   cap_state_t        capture FSM encoding (IDLE/SKIP/CAPTURE/DONE)
//   DFE_DATA_WIDTH     default sample width (signed Q1.15)
//   DFE_DEPTH          default capture buffer depth
//   DFE_CNT_WIDTH      default width of skip/length/sample counters
package dfe_pkg;

  typedef enum logic [1:0] {
    CAP_IDLE    = 2'd0,
    CAP_SKIP    = 2'd1,
    CAP_CAPTURE = 2'd2,
    CAP_DONE    = 2'd3
  } cap_state_t;

  localparam int DFE_DATA_WIDTH = 16;
  localparam int DFE_DEPTH      = 64;
  localparam int DFE_CNT_WIDTH  = 16;

endpackage

// File: rtl/dfe_capture_fifo.sv
// First-word-fall-through FIFO holding captured DFE samples.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (empties the FIFO)
//   wr_en        write request; ignored while full (pre-edge level)
//   wr_data      sample to write
//   rd_en        read request; ignored while empty
//   rd_data      head entry, 0 while empty
//   full, empty  status from the current level
//   level        entries held (0..DEPTH)
module dfe_capture_fifo
  import dfe_pkg::*;
#(
  parameter int DATA_WIDTH = DFE_DATA_WIDTH,
  parameter int DEPTH      = DFE_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic signed [DATA_WIDTH-1:0]  wr_data,
  input  logic                          rd_en,
  output logic signed [DATA_WIDTH-1:0]  rd_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(DEPTH):0]        level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic signed [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]                wr_ptr;
  logic [AW-1:0]                rd_ptr;
  logic                         wr_ok;
  logic                         rd_ok;

  // A write while full is refused even if a read frees a slot on the same edge.
  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

  // Storage carries data only; no reset needed, empty masks stale contents.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/dfe_sample_capture.sv
// Capture sink at the output of the Phase-1 DFE chain. After arming it
// discards skip_len strobed samples, then stores up to capture_len samples
// (0 = unlimited) into a FWFT buffer that a host drains over valid/ready.
// Sticky flags record buffer drops and chain overflow/underflow while active.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   capture_en            level: 1 arms/runs capture, 0 returns to IDLE
//   skip_len, capture_len latched when arming
//   valid_in, sample_in   strobed chain samples
//   chain_ovf, chain_unf  chain saturation flags
//   clear_status          pulse clearing the sticky flags
//   rd_ready/rd_valid/rd_data  host read port (FWFT)
//   fill_level            entries held
//   stored_count          accepted writes since arming (saturating)
//   busy, done            SKIP-or-CAPTURE, DONE
//   drop_sticky, ovf_sticky, unf_sticky  sticky status
module dfe_sample_capture
  import dfe_pkg::*;
#(
  parameter int DATA_WIDTH = DFE_DATA_WIDTH,
  parameter int DEPTH      = DFE_DEPTH,
  parameter int CNT_WIDTH  = DFE_CNT_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          capture_en,
  input  logic [CNT_WIDTH-1:0]          skip_len,
  input  logic [CNT_WIDTH-1:0]          capture_len,
  input  logic                          valid_in,
  input  logic signed [DATA_WIDTH-1:0]  sample_in,
  input  logic                          chain_ovf,
  input  logic                          chain_unf,
  input  logic                          clear_status,
  input  logic                          rd_ready,
  output logic                          rd_valid,
  output logic signed [DATA_WIDTH-1:0]  rd_data,
  output logic [$clog2(DEPTH):0]        fill_level,
  output logic [CNT_WIDTH-1:0]          stored_count,
  output logic                          busy,
  output logic                          done,
  output logic                          drop_sticky,
  output logic                          ovf_sticky,
  output logic                          unf_sticky
);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  cap_state_t           state;
  cap_state_t           state_nxt;
  logic [CNT_WIDTH-1:0] skip_cnt;
  logic [CNT_WIDTH-1:0] len_reg;
  logic [CNT_WIDTH-1:0] stored_nxt;
  logic                 arm;
  logic                 skip_dec;
  logic                 wr_req;
  logic                 wr_ok;
  logic                 drop_evt;
  logic                 active;
  logic                 full;
  logic                 empty;

  assign stored_nxt = sat_inc(stored_count);
  assign wr_ok      = wr_req & ~full;
  assign drop_evt   = wr_req & full;
  assign active     = (state == CAP_SKIP) || (state == CAP_CAPTURE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CAP_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    arm       = 1'b0;
    skip_dec  = 1'b0;
    wr_req    = 1'b0;
    case (state)
      CAP_IDLE: begin
        if (capture_en) begin
          state_nxt = CAP_SKIP;
          arm       = 1'b1;
        end
      end
      CAP_SKIP: begin
        if (!capture_en) begin
          state_nxt = CAP_IDLE;
        end else if (skip_cnt == '0) begin
          state_nxt = CAP_CAPTURE;
        end else if (valid_in) begin
          skip_dec = 1'b1;
          // Last discarded sample moves us on so the next strobe is stored.
          if (skip_cnt == CNT_WIDTH'(1)) begin
            state_nxt = CAP_CAPTURE;
          end
        end
      end
      CAP_CAPTURE: begin
        if (!capture_en) begin
          state_nxt = CAP_IDLE;
        end else if (valid_in) begin
          wr_req = 1'b1;
          // Only accepted writes count toward the programmed length.
          if (!full && (len_reg != '0) && (stored_nxt == len_reg)) begin
            state_nxt = CAP_DONE;
          end
        end
      end
      CAP_DONE: begin
        if (!capture_en) begin
          state_nxt = CAP_IDLE;
        end
      end
      default: state_nxt = CAP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skip_cnt     <= '0;
      len_reg      <= '0;
      stored_count <= '0;
    end else begin
      if (arm) begin
        skip_cnt     <= skip_len;
        len_reg      <= capture_len;
        stored_count <= '0;
      end else begin
        if (skip_dec) begin
          skip_cnt <= skip_cnt - CNT_WIDTH'(1);
        end
        if (wr_ok) begin
          stored_count <= stored_nxt;
        end
      end
    end
  end

  // Sticky flags: a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_sticky <= 1'b0;
      ovf_sticky  <= 1'b0;
      unf_sticky  <= 1'b0;
    end else begin
      drop_sticky <= drop_evt | (drop_sticky & ~clear_status);
      ovf_sticky  <= (active & chain_ovf) | (ovf_sticky & ~clear_status);
      unf_sticky  <= (active & chain_unf) | (unf_sticky & ~clear_status);
    end
  end

  assign busy     = active;
  assign done     = (state == CAP_DONE);
  assign rd_valid = ~empty;

  dfe_capture_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_req),
    .wr_data (sample_in),
    .rd_en   (rd_ready),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .level   (fill_level)
  );

endmodule
